// File: rtl/salt_pkg.sv
// Shared opcode, register-enable and source-select encodings for the 4-bit micro.
`default_nettype none

package salt_pkg;

  localparam logic       OP_MOVE  = 1'b0;
  localparam logic [2:0] OP_ALU   = 3'b100;
  localparam logic [3:0] OP_LDI_I = 4'hA;
  localparam logic [3:0] OP_LDI_M = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_JZ    = 4'hD;
  localparam logic [3:0] OP_CALL  = 4'hE;
  localparam logic [3:0] OP_MISC  = 4'hF;

  localparam logic [3:0] MISC_RET   = 4'h0;
  localparam logic [3:0] MISC_INC_I = 4'h1;

  localparam int REN_X0 = 0;
  localparam int REN_X1 = 1;
  localparam int REN_Y0 = 2;
  localparam int REN_Y1 = 3;
  localparam int REN_R  = 4;
  localparam int REN_M  = 5;
  localparam int REN_I  = 6;
  localparam int REN_DM = 7;
  localparam int REN_O  = 8;

  localparam logic [3:0] SRC_IMM = 4'd8;

  // Move destination field order differs from reg_en bit order (o_reg sits at bit 8).
  function automatic int dest_to_ren(input logic [2:0] ddd);
    case (ddd)
      3'd0:    return REN_X0;
      3'd1:    return REN_X1;
      3'd2:    return REN_Y0;
      3'd3:    return REN_Y1;
      3'd4:    return REN_O;
      3'd5:    return REN_M;
      3'd6:    return REN_I;
      default: return REN_DM;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/return_stack.sv
// LIFO of return addresses; push and pop are ignored when full / empty respectively.
`default_nettype none

module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]   mem_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] top_idx;

  assign top_idx = sp_q - SPW'(1);
  assign dout    = mem_q[top_idx[AW-1:0]];
  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !full) begin
      mem_q[sp_q[AW-1:0]] <= din;
      sp_q                <= sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SPW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_sequencer.sv
// Fetch/decode/flow-control front end: owns the PC, page jumps, jz and call/ret.
`default_nettype none

module program_sequencer
  import salt_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            hold,
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
  output logic [PC_W-1:0] pm_addr,
  output logic [3:0]      nibble_ir,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            x_sel,
  output logic            y_sel,
  output logic            i_sel,
  output logic            sync_reset,
  output logic            stack_err
);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt, stk_dout;
  logic            sync_reset_q;
  logic            stack_err_q, stack_err_d;
  logic            push, pop, stk_full, stk_empty;
  logic            suppress;
  logic [8:0]      reg_en_raw;
  logic [3:0]      op_hi, op_lo;

  assign op_hi      = pm_data[7:4];
  assign op_lo      = pm_data[3:0];
  assign suppress   = sync_reset_q | hold;
  assign pc_inc     = pc_q + PC_W'(1);
  assign tgt        = {pc_q[PC_W-1:4], op_lo};
  assign pm_addr    = pc_q;
  assign nibble_ir  = op_lo;
  assign sync_reset = sync_reset_q;
  assign stack_err  = stack_err_q;
  assign reg_en     = suppress ? 9'd0 : reg_en_raw;

  always_comb begin
    reg_en_raw = '0;
    source_sel = '0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    i_sel      = 1'b0;
    if (pm_data[7] == OP_MOVE) begin
      source_sel                           = op_lo;
      reg_en_raw[dest_to_ren(pm_data[6:4])] = 1'b1;
    end else if (pm_data[7:5] == OP_ALU) begin
      x_sel             = pm_data[4];
      y_sel             = pm_data[3];
      reg_en_raw[REN_R] = 1'b1;
    end else begin
      case (op_hi)
        OP_LDI_I: begin
          source_sel        = SRC_IMM;
          reg_en_raw[REN_I] = 1'b1;
        end
        OP_LDI_M: begin
          source_sel        = SRC_IMM;
          reg_en_raw[REN_M] = 1'b1;
        end
        OP_MISC: begin
          if (op_lo == MISC_INC_I) begin
            reg_en_raw[REN_I] = 1'b1;
            i_sel             = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Flow control; a stalled cycle leaves every piece of state untouched.
  always_comb begin
    pc_d        = pc_inc;
    push        = 1'b0;
    pop         = 1'b0;
    stack_err_d = stack_err_q;
    case (op_hi)
      OP_JMP: pc_d = tgt;
      OP_JZ:  if (r_eq_0) pc_d = tgt;
      OP_CALL: begin
        if (!stk_full) begin
          push = 1'b1;
          pc_d = tgt;
        end else begin
          stack_err_d = 1'b1;
        end
      end
      OP_MISC: begin
        if (op_lo == MISC_RET) begin
          if (!stk_empty) begin
            pop  = 1'b1;
            pc_d = stk_dout;
          end else begin
            stack_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (suppress) begin
      push        = 1'b0;
      pop         = 1'b0;
      pc_d        = sync_reset_q ? '0 : pc_q;
      stack_err_d = stack_err_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= '0;
      sync_reset_q <= 1'b1;
      stack_err_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      sync_reset_q <= 1'b0;
      stack_err_q  <= stack_err_d;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (pc_inc),
    .dout    (stk_dout),
    .full    (stk_full),
    .empty   (stk_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer with an asynchronous ROM model.
`default_nettype none

module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hold = 1'b0;
  logic       r_eq_0 = 1'b0;
  logic [7:0] pm_data;
  logic [7:0] pm_addr;
  logic [3:0] nibble_ir, source_sel;
  logic [8:0] reg_en;
  logic       x_sel, y_sel, i_sel, sync_reset, stack_err;
  logic [7:0] rom [256];

  int checks = 0;
  int errors = 0;

  assign pm_data = rom[pm_addr];

  always #5 clk = ~clk;

  program_sequencer #(.PC_W(8), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hold       (hold),
    .pm_data    (pm_data),
    .r_eq_0     (r_eq_0),
    .pm_addr    (pm_addr),
    .nibble_ir  (nibble_ir),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .i_sel      (i_sel),
    .sync_reset (sync_reset),
    .stack_err  (stack_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  // Reset held 3 cycles; returns in the sync_reset cycle with PC at 0.
  task automatic do_reset();
    hold    = 1'b0;
    r_eq_0  = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic run_to(input logic [7:0] a);
    int n = 0;
    while (pm_addr !== a && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (pm_addr !== a) begin
      errors++;
      $display("FAIL run_to: pm_addr=%h required=%h", pm_addr, a);
    end
  endtask

  task automatic test_reset();
    fill_rom(8'h28);
    hold    = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if (pm_addr !== 8'h00 || sync_reset !== 1'b1 || stack_err !== 1'b0 || reg_en !== 9'h000) begin
      errors++;
      $display("FAIL reset_state: addr=%h sr=%b err=%b en=%h required 00/1/0/000", pm_addr, sync_reset, stack_err, reg_en);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (pm_addr !== 8'h00 || sync_reset !== 1'b1 || reg_en !== 9'h000) begin
      errors++;
      $display("FAIL boot_sync_cycle: addr=%h sr=%b en=%h required 00/1/000", pm_addr, sync_reset, reg_en);
    end
    step();
    checks++;
    if (pm_addr !== 8'h00 || sync_reset !== 1'b0 || reg_en !== 9'h004) begin
      errors++;
      $display("FAIL boot_first_exec: addr=%h sr=%b en=%h required 00/0/004", pm_addr, sync_reset, reg_en);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (pm_addr !== 8'(k)) begin
        errors++;
        $display("FAIL boot_incr: addr=%h required=%h", pm_addr, 8'(k));
      end
    end
  endtask

  task automatic test_decode();
    rom[pm_addr] = 8'h28;
    #1;
    checks++;
    if (source_sel !== 4'd8 || reg_en !== 9'h004 || nibble_ir !== 4'h8) begin
      errors++;
      $display("FAIL dec_move_y0: src=%h en=%h nib=%h required 8/004/8", source_sel, reg_en, nibble_ir);
    end
    rom[pm_addr] = 8'h45;
    #1;
    checks++;
    if (source_sel !== 4'd5 || reg_en !== 9'h100) begin
      errors++;
      $display("FAIL dec_move_oreg: src=%h en=%h required 5/100", source_sel, reg_en);
    end
    rom[pm_addr] = 8'h9A;
    #1;
    checks++;
    if (reg_en !== 9'h010 || x_sel !== 1'b1 || y_sel !== 1'b1 || source_sel !== 4'd0) begin
      errors++;
      $display("FAIL dec_alu: en=%h x=%b y=%b src=%h required 010/1/1/0", reg_en, x_sel, y_sel, source_sel);
    end
    rom[pm_addr] = 8'hF1;
    #1;
    checks++;
    if (reg_en !== 9'h040 || i_sel !== 1'b1) begin
      errors++;
      $display("FAIL dec_inc_i: en=%h isel=%b required 040/1", reg_en, i_sel);
    end
    rom[pm_addr] = 8'hA5;
    #1;
    checks++;
    if (reg_en !== 9'h040 || i_sel !== 1'b0 || source_sel !== 4'd8) begin
      errors++;
      $display("FAIL dec_ldi_i: en=%h isel=%b src=%h required 040/0/8", reg_en, i_sel, source_sel);
    end
    rom[pm_addr] = 8'hB3;
    #1;
    checks++;
    if (reg_en !== 9'h020 || source_sel !== 4'd8) begin
      errors++;
      $display("FAIL dec_ldi_m: en=%h src=%h required 020/8", reg_en, source_sel);
    end
    rom[pm_addr] = 8'h28;
    hold = 1'b1;
    #1;
    checks++;
    if (reg_en !== 9'h000) begin
      errors++;
      $display("FAIL dec_hold_suppress: en=%h required 000", reg_en);
    end
    hold = 1'b0;
  endtask

  task automatic test_jumps();
    fill_rom(8'hF2);
    rom[8'h23] = 8'hC7;
    rom[8'h30] = 8'hD5;
    rom[8'h31] = 8'hC0;
    do_reset();
    run_to(8'h23);
    step();
    checks++;
    if (pm_addr !== 8'h27) begin
      errors++;
      $display("FAIL jmp: pc=%h required=27", pm_addr);
    end
    run_to(8'h30);
    r_eq_0 = 1'b0;
    step();
    checks++;
    if (pm_addr !== 8'h31) begin
      errors++;
      $display("FAIL jz_not_taken: pc=%h required=31", pm_addr);
    end
    step();
    checks++;
    if (pm_addr !== 8'h30) begin
      errors++;
      $display("FAIL jmp_back: pc=%h required=30", pm_addr);
    end
    r_eq_0 = 1'b1;
    step();
    r_eq_0 = 1'b0;
    checks++;
    if (pm_addr !== 8'h35) begin
      errors++;
      $display("FAIL jz_taken: pc=%h required=35", pm_addr);
    end
    run_to(8'hFF);
    step();
    checks++;
    if (pm_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h required=00", pm_addr);
    end
  endtask

  task automatic test_call_ret();
    fill_rom(8'hF2);
    rom[8'h10] = 8'hE8;
    rom[8'h18] = 8'hF0;
    do_reset();
    run_to(8'h10);
    step();
    checks++;
    if (pm_addr !== 8'h18 || dut.u_stack.sp_q !== 3'd1) begin
      errors++;
      $display("FAIL call: pc=%h sp=%0d required 18/1", pm_addr, dut.u_stack.sp_q);
    end
    step();
    checks++;
    if (pm_addr !== 8'h11 || dut.u_stack.sp_q !== 3'd0 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL ret: pc=%h sp=%0d err=%b required 11/0/0", pm_addr, dut.u_stack.sp_q, stack_err);
    end
  endtask

  task automatic test_overflow();
    fill_rom(8'hF2);
    rom[8'h10] = 8'hE8;
    rom[8'h18] = 8'hEA;
    rom[8'h1A] = 8'hEC;
    rom[8'h1C] = 8'hEE;
    rom[8'h1E] = 8'hE0;
    rom[8'h1F] = 8'hF0;
    do_reset();
    run_to(8'h10);
    repeat (4) step();
    checks++;
    if (pm_addr !== 8'h1E || stack_err !== 1'b0 || dut.u_stack.sp_q !== 3'd4) begin
      errors++;
      $display("FAIL nest4: pc=%h err=%b sp=%0d required 1e/0/4", pm_addr, stack_err, dut.u_stack.sp_q);
    end
    step();
    checks++;
    if (pm_addr !== 8'h1F || stack_err !== 1'b1 || dut.u_stack.sp_q !== 3'd4) begin
      errors++;
      $display("FAIL call_overflow: pc=%h err=%b sp=%0d required 1f/1/4", pm_addr, stack_err, dut.u_stack.sp_q);
    end
    step();
    checks++;
    if (pm_addr !== 8'h1D || dut.u_stack.sp_q !== 3'd3) begin
      errors++;
      $display("FAIL ret_after_overflow: pc=%h sp=%0d required 1d/3", pm_addr, dut.u_stack.sp_q);
    end
  endtask

  task automatic test_reset_mid_call();
    do_reset();
    checks++;
    if (stack_err !== 1'b0 || dut.u_stack.sp_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_clears_stack: err=%b sp=%0d required 0/0", stack_err, dut.u_stack.sp_q);
    end
  endtask

  task automatic test_underflow();
    fill_rom(8'hF2);
    rom[8'h40] = 8'hF0;
    do_reset();
    run_to(8'h40);
    step();
    checks++;
    if (pm_addr !== 8'h41 || stack_err !== 1'b1) begin
      errors++;
      $display("FAIL ret_underflow: pc=%h err=%b required 41/1", pm_addr, stack_err);
    end
    step();
    checks++;
    if (stack_err !== 1'b1 || pm_addr !== 8'h42) begin
      errors++;
      $display("FAIL err_sticky: pc=%h err=%b required 42/1", pm_addr, stack_err);
    end
  endtask

  task automatic test_hold();
    fill_rom(8'hF2);
    rom[8'h50] = 8'hE3;
    rom[8'h53] = 8'hF0;
    do_reset();
    run_to(8'h50);
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (pm_addr !== 8'h50 || dut.u_stack.sp_q !== 3'd0 || reg_en !== 9'h000) begin
        errors++;
        $display("FAIL hold_freeze: pc=%h sp=%0d en=%h required 50/0/000", pm_addr, dut.u_stack.sp_q, reg_en);
      end
    end
    hold = 1'b0;
    step();
    checks++;
    if (pm_addr !== 8'h53 || dut.u_stack.sp_q !== 3'd1) begin
      errors++;
      $display("FAIL hold_release_call: pc=%h sp=%0d required 53/1", pm_addr, dut.u_stack.sp_q);
    end
    step();
    checks++;
    if (pm_addr !== 8'h51 || dut.u_stack.sp_q !== 3'd0 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL hold_ret: pc=%h sp=%0d err=%b required 51/0/0", pm_addr, dut.u_stack.sp_q, stack_err);
    end
  endtask

  initial begin
    fill_rom(8'hF2);
    test_reset();
    test_decode();
    test_jumps();
    test_call_ret();
    test_overflow();
    test_reset_mid_call();
    test_underflow();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
